// File: rtl/decryption_pkg.sv
// Shared constants for the decryption configuration register file:
// fixed register addresses, STATUS bit positions and the default key reset set.
package decryption_pkg;

  localparam logic [7:0] ADDR_SELECT = 8'h00;
  localparam logic [7:0] ADDR_COMMIT = 8'h02;
  localparam logic [7:0] ADDR_STATUS = 8'h04;

  localparam int STATUS_PENDING_BIT = 0;
  localparam int STATUS_DIRTY_BIT   = 1;

  // key 0 (caesar) in the LSBs, then scytale, then zigzag
  localparam logic [47:0] KEY_RESET_DEFAULT = {16'h0002, 16'hFFFF, 16'h0000};

endpackage

// File: rtl/decryption_key_bank.sv
// One configuration register: a software-visible shadow copy and the active
// copy driven into the datapath. With SHADOW_EN=0 the shadow stage is removed
// and writes land directly in the active register.
module decryption_key_bank #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SHADOW_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             commit,
  output logic [WIDTH-1:0] shadow_q,
  output logic [WIDTH-1:0] active_q
);

  if (SHADOW_EN) begin : g_shadow
    // software write stages into the shadow copy
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  shadow_q <= RESET_VAL;
      else if (we) shadow_q <= wdata;
    end

    // commit copies the pre-edge shadow value, so a same-cycle write waits for the next commit
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      active_q <= RESET_VAL;
      else if (commit) active_q <= shadow_q;
    end
  end else begin : g_direct
    logic unused_commit;
    assign unused_commit = commit;
    assign shadow_q      = active_q;

    // software write goes straight to the active copy
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  active_q <= RESET_VAL;
      else if (we) active_q <= wdata;
    end
  end

endmodule

// File: rtl/decryption_cfg_regfile.sv
// Configuration register file for the decryption top level: SELECT plus
// NUM_KEYS key registers at KEY_BASE + i*KEY_STRIDE, with COMMIT and STATUS.
// Build option: define DECRYPTION_REGFILE_SHADOW_EN to stage writes in shadow
// registers and apply them atomically on COMMIT once busy is low. Without it,
// writes update the active outputs directly.
module decryption_cfg_regfile
  import decryption_pkg::*;
#(
  parameter int                             ADDR_WIDTH = 8,
  parameter int                             REG_WIDTH  = 16,
  parameter int                             NUM_KEYS   = 3,
  parameter int                             SEL_WIDTH  = 2,
  parameter logic [ADDR_WIDTH-1:0]          KEY_BASE   = ADDR_WIDTH'('h10),
  parameter int                             KEY_STRIDE = 2,
  parameter logic [NUM_KEYS*REG_WIDTH-1:0]  KEY_RESET  = KEY_RESET_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_WIDTH-1:0]         addr,
  input  logic                          read,
  input  logic                          write,
  input  logic [REG_WIDTH-1:0]          wdata,
  input  logic                          busy,
  output logic [REG_WIDTH-1:0]          rdata,
  output logic                          done,
  output logic                          error,
  output logic [REG_WIDTH-1:0]          select,
  output logic [NUM_KEYS*REG_WIDTH-1:0] keys,
  output logic                          cfg_update
);

`ifdef DECRYPTION_REGFILE_SHADOW_EN
  localparam bit SHADOW_EN = 1'b1;
`else
  localparam bit SHADOW_EN = 1'b0;
`endif

  localparam logic [ADDR_WIDTH-1:0] A_SELECT = ADDR_WIDTH'(ADDR_SELECT);
  localparam logic [ADDR_WIDTH-1:0] A_COMMIT = ADDR_WIDTH'(ADDR_COMMIT);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(ADDR_STATUS);

  logic                 access, acc_err, wr_ok;
  logic                 sel_hit, commit_hit, status_hit, map_hit;
  logic                 sel_we, shadow_we, apply;
  logic [NUM_KEYS-1:0]  key_hit, key_we;
  logic [SEL_WIDTH-1:0] sel_shadow, sel_active;
  logic [REG_WIDTH-1:0] key_shadow [NUM_KEYS];
  logic [REG_WIDTH-1:0] status_word, rd_val;

  assign access     = read | write;
  assign sel_hit    = (addr == A_SELECT);
  assign commit_hit = (addr == A_COMMIT);
  assign status_hit = (addr == A_STATUS);

  // key address decode over the strided map
  always_comb begin
    key_hit = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      key_hit[i] = (addr == ADDR_WIDTH'(KEY_BASE + i * KEY_STRIDE));
  end

  assign map_hit = sel_hit | commit_hit | status_hit | (|key_hit);
  assign acc_err = access & (~map_hit | (read & write) | (write & status_hit));
  assign wr_ok   = write & ~acc_err;

  assign sel_we    = wr_ok & sel_hit;
  assign key_we    = wr_ok ? key_hit : '0;
  assign shadow_we = sel_we | (|key_we);

  decryption_key_bank #(
    .WIDTH     (SEL_WIDTH),
    .RESET_VAL ('0),
    .SHADOW_EN (SHADOW_EN)
  ) u_sel_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (sel_we),
    .wdata    (wdata[SEL_WIDTH-1:0]),
    .commit   (apply),
    .shadow_q (sel_shadow),
    .active_q (sel_active)
  );

  assign select = REG_WIDTH'(sel_active);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    decryption_key_bank #(
      .WIDTH     (REG_WIDTH),
      .RESET_VAL (KEY_RESET[i*REG_WIDTH +: REG_WIDTH]),
      .SHADOW_EN (SHADOW_EN)
    ) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (key_we[i]),
      .wdata    (wdata),
      .commit   (apply),
      .shadow_q (key_shadow[i]),
      .active_q (keys[i*REG_WIDTH +: REG_WIDTH])
    );
  end

`ifdef DECRYPTION_REGFILE_SHADOW_EN
  logic commit_req, pending, dirty, apply_q, wr_at_apply;

  assign commit_req = wr_ok & commit_hit;
  assign apply      = ~busy & (pending | commit_req);

  // status word: pending and dirty flags
  always_comb begin
    status_word                     = '0;
    status_word[STATUS_PENDING_BIT] = pending;
    status_word[STATUS_DIRTY_BIT]   = dirty;
  end

  // commit tracking; dirty clears with cfg_update unless the apply cycle also wrote a shadow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= 1'b0;
      dirty       <= 1'b0;
      apply_q     <= 1'b0;
      wr_at_apply <= 1'b0;
      cfg_update  <= 1'b0;
    end else begin
      pending     <= (pending | commit_req) & busy;
      apply_q     <= apply;
      wr_at_apply <= apply & shadow_we;
      cfg_update  <= apply_q;
      dirty       <= shadow_we | (apply_q ? wr_at_apply : dirty);
    end
  end
`else
  logic unused_busy;
  assign unused_busy = busy;
  assign apply       = 1'b0;
  assign status_word = '0;

  // direct mode: announce every successful SELECT/key write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_update <= 1'b0;
    else        cfg_update <= shadow_we;
  end
`endif

  // read mux; reads return the software-visible (shadow) copy
  always_comb begin
    rd_val = '0;
    if (sel_hit)    rd_val = REG_WIDTH'(sel_shadow);
    if (status_hit) rd_val = status_word;
    for (int i = 0; i < NUM_KEYS; i++)
      if (key_hit[i]) rd_val = key_shadow[i];
  end

  // access completion and read data; errors and writes leave rdata untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      done  <= access;
      error <= acc_err;
      if (read && !acc_err) rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_decryption_cfg_regfile.sv
// Directed self-checking bench for decryption_cfg_regfile. Expectations for
// both build variants (DECRYPTION_REGFILE_SHADOW_EN defined or not) are
// written out by hand below.
module tb_decryption_cfg_regfile;

  logic        clk = 1'b0;
  logic        rst_n, read, write, busy;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata, select;
  logic [47:0] keys;
  logic        done, error, cfg_update;

  int vectors = 0;
  int miscompares = 0;

  logic        d1, e1, c1, d2, e2, c2;
  logic [15:0] r1;
  logic [47:0] k1;

  decryption_cfg_regfile dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .read       (read),
    .write      (write),
    .wdata      (wdata),
    .busy       (busy),
    .rdata      (rdata),
    .done       (done),
    .error      (error),
    .select     (select),
    .keys       (keys),
    .cfg_update (cfg_update)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one strobe cycle; samples the cycle after the strobe (N1) and the one after (N2)
  task automatic access(input logic r, input logic w, input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    read = r; write = w; addr = a; wdata = d;
    @(negedge clk);
    d1 = done; e1 = error; r1 = rdata; c1 = cfg_update; k1 = keys;
    read = 1'b0; write = 1'b0;
    @(negedge clk);
    d2 = done; e2 = error; c2 = cfg_update;
  endtask

  task automatic chk_acc(input string tag, input logic exp_err);
    chk({tag, "_done"},  48'(d1), 48'(1'b1));
    chk({tag, "_err"},   48'(e1), 48'(exp_err));
    chk({tag, "_done2"}, 48'(d2), 48'(1'b0));
    chk({tag, "_err2"},  48'(e2), 48'(1'b0));
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [15:0] exp);
    access(1'b1, 1'b0, a, 16'h0);
    chk_acc(tag, 1'b0);
    chk({tag, "_data"}, 48'(r1), 48'(exp));
  endtask

  initial begin
    rst_n = 1'b0; read = 1'b0; write = 1'b0; busy = 1'b0; addr = '0; wdata = '0;
    #12;
    chk("rst_select", 48'(select), 48'h0);
    chk("rst_keys", keys, 48'h0002_FFFF_0000);
    chk("rst_rdata", 48'(rdata), 48'h0);
    chk("rst_done", 48'(done), 48'h0);
    chk("rst_error", 48'(error), 48'h0);
    chk("rst_cfg", 48'(cfg_update), 48'h0);
    @(negedge clk);
    rst_n = 1'b1;

    rd("rd_k0", 8'h10, 16'h0000);
    rd("rd_k1", 8'h12, 16'hFFFF);
    rd("rd_k2", 8'h14, 16'h0002);
    rd("rd_sel", 8'h00, 16'h0000);

    // key 0 = 7
    access(1'b0, 1'b1, 8'h10, 16'h0007);
    chk_acc("wr_k0", 1'b0);
    chk("wr_k0_rdata", 48'(r1), 48'h0);
`ifdef DECRYPTION_REGFILE_SHADOW_EN
    chk("wr_k0_active", 48'(keys[15:0]), 48'h0);
    chk("wr_k0_cfg", 48'(c1), 48'h0);
    rd("rd_k0_shadow", 8'h10, 16'h0007);
    rd("st_dirty", 8'h04, 16'h0002);
    access(1'b0, 1'b1, 8'h02, 16'h1234);
    chk_acc("commit_idle", 1'b0);
    chk("commit_keys", 48'(k1[15:0]), 48'h7);
    chk("commit_cfg_n1", 48'(c1), 48'h0);
    chk("commit_cfg_n2", 48'(c2), 48'h1);
    @(negedge clk);
    chk("commit_cfg_n3", 48'(cfg_update), 48'h0);
    rd("st_clean", 8'h04, 16'h0000);
`else
    chk("wr_k0_active", 48'(k1[15:0]), 48'h7);
    chk("wr_k0_cfg", 48'(c1), 48'h1);
    chk("wr_k0_cfg2", 48'(c2), 48'h0);
    rd("rd_k0", 8'h10, 16'h0007);
    rd("st_zero", 8'h04, 16'h0000);
    access(1'b0, 1'b1, 8'h02, 16'h1234);
    chk_acc("commit_noop", 1'b0);
    chk("commit_noop_cfg", 48'(c1), 48'h0);
    chk("commit_noop_keys", k1, 48'h0002_FFFF_0007);
`endif

    // key 1 while the datapath is busy
    busy = 1'b1;
    access(1'b0, 1'b1, 8'h12, 16'h0005);
    chk_acc("wr_k1", 1'b0);
`ifdef DECRYPTION_REGFILE_SHADOW_EN
    chk("wr_k1_active", 48'(k1[31:16]), 48'hFFFF);
    access(1'b0, 1'b1, 8'h02, 16'h0000);
    chk_acc("commit_busy", 1'b0);
    chk("commit_busy_cfg", 48'(c2), 48'h0);
    rd("st_pending", 8'h04, 16'h0003);
    chk("pending_keys", 48'(keys[31:16]), 48'hFFFF);
    access(1'b0, 1'b1, 8'h12, 16'h0009);
    chk_acc("wr_k1_pend", 1'b0);
    access(1'b0, 1'b1, 8'h02, 16'h0000);
    chk_acc("commit_merge", 1'b0);
    chk("merge_keys", 48'(keys[31:16]), 48'hFFFF);
    busy = 1'b0;
    @(negedge clk);
    chk("apply_keys", 48'(keys[31:16]), 48'h9);
    chk("apply_cfg0", 48'(cfg_update), 48'h0);
    @(negedge clk);
    chk("apply_cfg1", 48'(cfg_update), 48'h1);
    @(negedge clk);
    chk("apply_cfg2", 48'(cfg_update), 48'h0);
    rd("st_after_apply", 8'h04, 16'h0000);
`else
    chk("wr_k1_active", 48'(k1[31:16]), 48'h5);
    chk("wr_k1_cfg", 48'(c1), 48'h1);
    busy = 1'b0;
    access(1'b0, 1'b1, 8'h12, 16'h0009);
    chk_acc("wr_k1b", 1'b0);
    chk("wr_k1b_active", 48'(k1[31:16]), 48'h9);
`endif

    // key 2 = 4
    access(1'b0, 1'b1, 8'h14, 16'h0004);
    chk_acc("wr_k2", 1'b0);
`ifdef DECRYPTION_REGFILE_SHADOW_EN
    chk("wr_k2_active", 48'(k1[47:32]), 48'h2);
    chk("wr_k2_cfg", 48'(c1), 48'h0);
    rd("st_dirty2", 8'h04, 16'h0002);
    access(1'b0, 1'b1, 8'h02, 16'h0000);
    chk_acc("commit_k2", 1'b0);
    chk("commit_k2_keys", k1, 48'h0004_0009_0007);
`else
    chk("wr_k2_active", 48'(k1[47:32]), 48'h4);
    chk("wr_k2_cfg", 48'(c1), 48'h1);
    chk("wr_k2_cfg2", 48'(c2), 48'h0);
    rd("st_zero2", 8'h04, 16'h0000);
`endif

    // error cases: rdata holds 7 from this read
    rd("rd_k0_pre_err", 8'h10, 16'h0007);
    access(1'b1, 1'b0, 8'h16, 16'h0000);
    chk_acc("rd_k3", 1'b1);
    chk("rd_k3_rdata", 48'(r1), 48'h7);
    access(1'b0, 1'b1, 8'h16, 16'hAAAA);
    chk_acc("wr_k3", 1'b1);
    chk("wr_k3_cfg", 48'(c1), 48'h0);
    access(1'b0, 1'b1, 8'h04, 16'hFFFF);
    chk_acc("wr_status", 1'b1);
    access(1'b1, 1'b1, 8'h00, 16'h0003);
    chk_acc("rd_wr_both", 1'b1);
    chk("rd_wr_rdata", 48'(r1), 48'h7);
    chk("rd_wr_select", 48'(select), 48'h0);
    access(1'b1, 1'b0, 8'h11, 16'h0000);
    chk_acc("rd_odd", 1'b1);
    chk("err_keys", keys, 48'h0004_0009_0007);
    rd("rd_sel_unchanged", 8'h00, 16'h0000);
    rd("rd_commit", 8'h02, 16'h0000);

    // SELECT masking, then reset with a commit outstanding
    access(1'b0, 1'b1, 8'h00, 16'hFFFF);
    chk_acc("wr_sel", 1'b0);
    rd("rd_sel_mask", 8'h00, 16'h0003);
`ifdef DECRYPTION_REGFILE_SHADOW_EN
    chk("sel_active_hold", 48'(select), 48'h0);
    busy = 1'b1;
    access(1'b0, 1'b1, 8'h02, 16'h0000);
    chk_acc("commit_sel_busy", 1'b0);
    rd("st_pend_sel", 8'h04, 16'h0003);
`else
    chk("sel_active", 48'(select), 48'h3);
`endif
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_select", 48'(select), 48'h0);
    chk("arst_keys", keys, 48'h0002_FFFF_0000);
    chk("arst_rdata", 48'(rdata), 48'h0);
    chk("arst_done", 48'(done), 48'h0);
    chk("arst_cfg", 48'(cfg_update), 48'h0);
    @(negedge clk);
    rst_n = 1'b1;
    busy  = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_select", 48'(select), 48'h0);
    chk("post_rst_cfg", 48'(cfg_update), 48'h0);
    rd("post_rst_status", 8'h04, 16'h0000);
    rd("post_rst_k0", 8'h10, 16'h0000);
    rd("post_rst_sel", 8'h00, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
